vending_machine_multi: RTL

Parametrised multi-product vending controller, successor to the single-product two-unit soda FSM.
- Accumulates credit from 1/2/5-unit coins and vends one of N_PRODUCTS at a common PRICE.
- Tracks per-product stock and supports cancel/refund.
- Returns change greedily, one coin per cycle.
- Sits between the coin acceptor / keypad front-end and the dispenser and coin-hopper drivers.

---
 rtl/vending_pkg.sv | 33 +++
 rtl/vend_change_dispenser.sv | 43 ++++
 rtl/vending_machine_multi.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// Shared coin encodings, controller states and coin arithmetic helpers
// for the multi-product vending controller.
package vending_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_5    = 2'b11;

  typedef enum logic [1:0] {
    COLLECT,
    VEND,
    CHANGE
  } state_t;

  function automatic logic [2:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_1:  return 3'd1;
      COIN_2:  return 3'd2;
      COIN_5:  return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  // Greedy pick: the biggest coin that still fits in the remaining amount.
  function automatic logic [1:0] largest_coin(input logic [15:0] amount);
    if (amount >= 16'd5)      return COIN_5;
    else if (amount >= 16'd2) return COIN_2;
    else if (amount >= 16'd1) return COIN_1;
    else                      return COIN_NONE;
  endfunction

endpackage

// File: rtl/vend_change_dispenser.sv
// Greedy change payout: loads an amount on start, then emits one registered
// coin per cycle until nothing is left. done flags the cycle issuing the last coin.
module vend_change_dispenser
  import vending_pkg::*;
#(
  parameter int CREDIT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CREDIT_W-1:0] load,
  output logic [1:0]          coin,
  output logic [CREDIT_W-1:0] remaining_next,
  output logic                done
);

  logic [CREDIT_W-1:0] remaining;
  logic [CREDIT_W-1:0] src;
  logic                active;
  logic                issuing;
  logic [1:0]          code;

  always_comb begin
    issuing        = start || active;
    src            = start ? load : remaining;
    code           = issuing ? largest_coin(16'(src)) : COIN_NONE;
    remaining_next = src - CREDIT_W'(coin_value(code));
    done           = issuing && (remaining_next == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      remaining <= '0;
      active    <= 1'b0;
      coin      <= COIN_NONE;
    end else begin
      remaining <= remaining_next;
      active    <= issuing && (remaining_next != '0);
      coin      <= code;
    end
  end

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: credit accumulation, per-product stock,
// buy/cancel handling and greedy change through vend_change_dispenser.
module vending_machine_multi
  import vending_pkg::*;
#(
  parameter int N_PRODUCTS = 4,
  parameter int PRICE      = 2,
  parameter int CREDIT_W   = 4,
  parameter int MAX_CREDIT = 9,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 10,
  localparam int SEL_W     = (N_PRODUCTS > 1) ? $clog2(N_PRODUCTS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            coin_in,
  input  logic                  buy,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  cancel,
  input  logic                  restock,
  output logic [N_PRODUCTS-1:0] vend,
  output logic [1:0]            coin_out,
  output logic [1:0]            coin_reject,
  output logic [CREDIT_W-1:0]   credit,
  output logic [N_PRODUCTS-1:0] sold_out,
  output logic                  deny,
  output logic                  busy
);

  localparam int SUM_W = CREDIT_W + 3;
  localparam logic [SUM_W-1:0]   PRICE_S   = SUM_W'(PRICE);
  localparam logic [SUM_W-1:0]   MAX_S     = SUM_W'(MAX_CREDIT);
  localparam logic [STOCK_W-1:0] STOCK_RST = STOCK_W'(STOCK_INIT);

  state_t              state;
  logic [STOCK_W-1:0]  stock     [N_PRODUCTS];
  logic [STOCK_W-1:0]  stock_nxt [N_PRODUCTS];
  logic [SEL_W-1:0]    sel_idx;
  logic                in_range;
  logic                coin_present;
  logic                cancel_go;
  logic                buy_try;
  logic                buy_ok;
  logic                coin_ok;
  logic [SUM_W-1:0]    credit_ext;
  logic [SUM_W-1:0]    coin_val;
  logic [SUM_W-1:0]    post_buy;
  logic [SUM_W-1:0]    post_coin;
  logic                disp_start;
  logic                disp_done;
  logic [CREDIT_W-1:0] disp_load;
  logic [CREDIT_W-1:0] disp_rem_next;

  // Buy is judged on the pre-coin credit; a same-cycle coin lands on top of it.
  always_comb begin
    in_range     = int'(sel) < N_PRODUCTS;
    sel_idx      = in_range ? sel : '0;
    coin_present = coin_in != COIN_NONE;
    credit_ext   = SUM_W'(credit);
    coin_val     = SUM_W'(coin_value(coin_in));
    cancel_go    = (state == COLLECT) && cancel && (credit != '0);
    buy_try      = (state == COLLECT) && buy && !cancel;
    buy_ok       = buy_try && (credit_ext >= PRICE_S) && in_range &&
                   (stock[sel_idx] != '0);
    post_buy     = buy_ok ? credit_ext - PRICE_S : credit_ext;
    coin_ok      = (state == COLLECT) && coin_present && (post_buy + coin_val <= MAX_S);
    post_coin    = coin_ok ? post_buy + coin_val : post_buy;
    disp_start   = cancel_go || ((state == VEND) && (credit != '0));
    disp_load    = (state == VEND) ? credit : CREDIT_W'(post_coin);
  end

  always_comb begin
    for (int i = 0; i < N_PRODUCTS; i++) begin
      stock_nxt[i] = restock ? STOCK_RST : stock[i];
    end
    if (buy_ok && !restock) begin
      stock_nxt[sel_idx] = stock[sel_idx] - STOCK_W'(1);
    end
  end

  vend_change_dispenser #(
    .CREDIT_W(CREDIT_W)
  ) u_dispenser (
    .clk           (clk),
    .reset         (reset),
    .start         (disp_start),
    .load          (disp_load),
    .coin          (coin_out),
    .remaining_next(disp_rem_next),
    .done          (disp_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= COLLECT;
      credit      <= '0;
      vend        <= '0;
      coin_reject <= COIN_NONE;
      deny        <= 1'b0;
      busy        <= 1'b0;
      sold_out    <= '0;
      for (int i = 0; i < N_PRODUCTS; i++) begin
        stock[i] <= STOCK_RST;
      end
    end else begin
      vend        <= '0;
      deny        <= 1'b0;
      coin_reject <= COIN_NONE;
      for (int i = 0; i < N_PRODUCTS; i++) begin
        stock[i]    <= stock_nxt[i];
        sold_out[i] <= stock_nxt[i] == '0;
      end
      case (state)
        COLLECT: begin
          if (coin_present && !coin_ok) coin_reject <= coin_in;
          if (cancel_go) begin
            credit <= disp_rem_next;
            state  <= disp_done ? COLLECT : CHANGE;
            busy   <= !disp_done;
          end else if (buy_ok) begin
            credit        <= CREDIT_W'(post_coin);
            vend[sel_idx] <= 1'b1;
            state         <= VEND;
            busy          <= 1'b1;
          end else begin
            credit <= CREDIT_W'(post_coin);
            deny   <= buy_try;
            busy   <= 1'b0;
          end
        end
        // A vend with no leftover credit has an idle dispenser, so credit stays 0.
        VEND, CHANGE: begin
          coin_reject <= coin_in;
          credit      <= disp_rem_next;
          if (((state == VEND) && (credit == '0)) || disp_done) begin
            state <= COLLECT;
            busy  <= 1'b0;
          end else begin
            state <= CHANGE;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= COLLECT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
